// File: rtl/vga_sync_if.sv
// Timing bundle produced by vga_sync: pixel/line counters plus registered sync decodes.
// Optional frame_start strobe is present only when VGA_FRAME_TICK_EN is defined.
`timescale 1ns/1ps
interface vga_sync_if;
  logic [9:0] horizontal_num;
  logic [9:0] vertical_num;
  logic       hsync;
  logic       vsync;
  logic       video_on;
`ifdef VGA_FRAME_TICK_EN
  logic       frame_start;
`endif

  modport master (
    output horizontal_num, vertical_num, hsync, vsync, video_on
`ifdef VGA_FRAME_TICK_EN
    , output frame_start
`endif
  );

  modport slave (
    input horizontal_num, vertical_num, hsync, vsync, video_on
`ifdef VGA_FRAME_TICK_EN
    , input frame_start
`endif
  );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: free-running column/line counters with sync and blanking
// decodes registered from next-state counts. Define VGA_FRAME_TICK_EN to add frame_start.
`timescale 1ns/1ps
module vga_sync #(
  parameter int HVID  = 640,
  parameter int HFP   = 16,
  parameter int HSYNC = 96,
  parameter int HBP   = 48,
  parameter int VVID  = 480,
  parameter int VFP   = 10,
  parameter int VSYNC = 2,
  parameter int VBP   = 33
) (
  input  logic         clk_25,
  input  logic         rst_n,
  vga_sync_if.master   vga
);

  localparam int HTOTAL = HVID + HFP + HSYNC + HBP;
  localparam int VTOTAL = VVID + VFP + VSYNC + VBP;

  localparam logic [9:0] H_MAX      = 10'(HTOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(VTOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(HVID);
  localparam logic [9:0] V_VIS      = 10'(VVID);
  localparam logic [9:0] HS_FIRST   = 10'(HVID + HFP);
  localparam logic [9:0] HS_LAST    = 10'(HVID + HFP + HSYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(VVID + VFP);
  localparam logic [9:0] VS_LAST    = 10'(VVID + VFP + VSYNC - 1);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_next, v_next;
  logic       h_wrap;
  logic       hsync_q, vsync_q, video_on_q;
  logic       hsync_d, vsync_d, video_on_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_wrap = (h_cnt >= H_MAX);
    h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt >= V_MAX) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Decoding the next counts lets the registered syncs line up with the counters they accompany.
  always_comb begin
    hsync_d    = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
    vsync_d    = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    video_on_d = (h_next < H_VIS) && (v_next < V_VIS);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt      <= H_MAX;
      v_cnt      <= V_MAX;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      h_cnt      <= h_next;
      v_cnt      <= v_next;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign vga.horizontal_num = h_cnt;
  assign vga.vertical_num   = v_cnt;
  assign vga.hsync          = hsync_q;
  assign vga.vsync          = vsync_q;
  assign vga.video_on       = video_on_q;

`ifdef VGA_FRAME_TICK_EN
  logic frame_start_q;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

  assign vga.frame_start = frame_start_q;
`endif

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter HVID, default 640, visible pixels per line.
REQ-002 SHALL have parameter HFP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter HSYNC, default 96, horizontal sync width in clocks.
REQ-004 SHALL have parameter HBP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter VVID, default 480, visible lines per frame.
REQ-006 SHALL have parameters VFP, VSYNC and VBP, defaults 10, 2 and 33, vertical porch and sync widths in lines.
REQ-007 SHALL have port clk_25  input  1  pixel clock, 25 MHz, rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-009 SHALL have port horizontal_num  output  10  current pixel column, 0..HTOTAL-1.
REQ-010 SHALL have port vertical_num  output  10  current line, 0..VTOTAL-1.
REQ-011 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-012 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-013 SHALL have port video_on  output  1  high only inside the visible area.

Function
REQ-014 SHALL define HTOTAL = HVID+HFP+HSYNC+HBP (800) and VTOTAL = VVID+VFP+VSYNC+VBP (525).
REQ-015 SHALL increment horizontal_num by 1 on every clk_25 edge, wrapping from HTOTAL-1 to 0.
REQ-016 SHALL increment vertical_num by 1 only on the edge where horizontal_num wraps, wrapping from VTOTAL-1 to 0 on that same edge.
REQ-017 SHALL drive hsync low exactly when horizontal_num is in [HVID+HFP, HVID+HFP+HSYNC-1] (656..751), otherwise high.
REQ-018 SHALL drive vsync low exactly when vertical_num is in [VVID+VFP, VVID+VFP+VSYNC-1] (490..491), otherwise high.
REQ-019 SHALL drive video_on high exactly when horizontal_num < HVID and vertical_num < VVID.
REQ-020 SHALL register hsync, vsync and video_on, decoding them from next-state counter values, so that in every cycle they match the horizontal_num/vertical_num presented in that same cycle; latency from counter to decode is zero cycles and no output glitches.
REQ-021 SHALL keep all counter arithmetic 10 bits wide, with no reachable value at or above HTOTAL or VTOTAL.
REQ-022 SHALL produce a horizontal wrap and a vertical wrap on the same edge at (HTOTAL-1, VTOTAL-1), yielding (0,0).

Reset
REQ-023 SHALL, while rst_n is low and independent of clk_25, force horizontal_num=HTOTAL-1 (799), vertical_num=VTOTAL-1 (524), hsync=1, vsync=1 and video_on=0.
REQ-024 SHALL, on the first clk_25 rising edge after rst_n deasserts, present (0,0) with video_on=1.
REQ-025 SHALL, on reset asserted mid-frame, abandon the current frame immediately and restart per REQ-024.

Configuration
REQ-026 SHALL, when macro VGA_FRAME_TICK_EN is defined, add output frame_start (1 bit, registered, reset 0), high for exactly one cycle while horizontal_num=0 and vertical_num=0.
REQ-027 SHALL, when VGA_FRAME_TICK_EN is undefined, omit the frame_start port and its logic entirely, with all other behaviour unchanged.

Verification
REQ-028 Release reset -> first edge shows (0,0), video_on=1, hsync=1, vsync=1; during reset (799,524), video_on=0.
REQ-029 Run one line -> hsync low for exactly 96 clocks starting at column 656; video_on high for columns 0..639 only.
REQ-030 Run one frame -> exactly 420000 clocks between successive (0,0); vsync low only on lines 490..491, for 1600 clocks.
REQ-031 At column 799, line 524 -> next edge gives (0,0); at column 799, line 10 -> next edge gives (0,11).
REQ-032 Assert rst_n low at (300,200) for 3 clocks -> outputs jump asynchronously to reset values; after release, restart at (0,0).
REQ-033 With VGA_FRAME_TICK_EN defined, run 2 frames -> exactly 2 single-cycle frame_start pulses, each coinciding with (0,0).
